// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// The owner keeps the UART for a whole burst; each byte waits for tx_busy to rise and fall.
module uart_tx_arbiter #(
  parameter int BYTE_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  meta_req,
  input  logic                  meta_valid,
  input  logic [BYTE_WIDTH-1:0] meta_byte,
  output logic                  meta_ack,
  input  logic                  data_req,
  input  logic                  data_valid,
  input  logic [BYTE_WIDTH-1:0] data_byte,
  output logic                  data_ack,
  output logic                  tran_uart,
  output logic [BYTE_WIDTH-1:0] tran_data,
  input  logic                  tx_busy,
  output logic [1:0]            grant,
  output logic [15:0]           byte_count,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GRANTED, STROBE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              grant_reg, grant_next;
  logic                    last_data_reg, last_data_next;
  logic [BYTE_WIDTH-1:0]   tran_data_reg, tran_data_next;
  logic                    tran_uart_reg, tran_uart_next;
  logic [1:0]              ack_reg, ack_next;
  logic [15:0]             byte_count_reg, byte_count_next;
  logic                    timeout_err_reg, timeout_err_next;
  logic [CNT_W-1:0]        wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]        wait_cnt_inc;

  // Requester inputs as vectors indexed like grant: 0 = meta, 1 = data.
  logic [1:0]              req_vec;
  logic [1:0]              valid_vec;
  logic [BYTE_WIDTH-1:0]   byte_in     [2];
  logic [BYTE_WIDTH-1:0]   byte_masked [2];
  logic                    owner_req;
  logic                    owner_valid;
  logic [BYTE_WIDTH-1:0]   owner_byte;

  assign req_vec    = {data_req, meta_req};
  assign valid_vec  = {data_valid, meta_valid};
  assign byte_in[0] = meta_byte;
  assign byte_in[1] = data_byte;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_owner_sel
      assign byte_masked[gi] = byte_in[gi] & {BYTE_WIDTH{grant_reg[gi]}};
    end
  endgenerate

  assign owner_req    = |(req_vec & grant_reg);
  assign owner_valid  = |(valid_vec & grant_reg);
  assign owner_byte   = byte_masked[0] | byte_masked[1];
  assign wait_cnt_inc = wait_cnt_reg + CNT_W'(1);

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_data_next   = last_data_reg;
    tran_data_next   = tran_data_reg;
    tran_uart_next   = 1'b0;
    ack_next         = 2'b00;
    byte_count_next  = byte_count_reg;
    timeout_err_next = timeout_err_reg;
    wait_cnt_next    = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (meta_req || data_req) begin
          state_next      = GRANTED;
          byte_count_next = 16'd0;
          if (meta_req && data_req)
            grant_next = last_data_reg ? 2'b01 : 2'b10;
          else
            grant_next = meta_req ? 2'b01 : 2'b10;
        end
      end
      GRANTED: begin
        if (!owner_req) begin
          state_next     = IDLE;
          grant_next     = 2'b00;
          last_data_next = grant_reg[1];
        end else if (owner_valid && !tx_busy) begin
          state_next     = STROBE;
          tran_data_next = owner_byte;
          tran_uart_next = 1'b1;
        end
      end
      STROBE: begin
        state_next    = WAIT_BUSY;
        wait_cnt_next = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
          // UART never answered: release the byte as dropped, without counting it.
          state_next       = GRANTED;
          timeout_err_next = 1'b1;
          ack_next         = grant_reg;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = GRANTED;
          ack_next   = grant_reg;
          if (byte_count_reg != 16'hFFFF)
            byte_count_next = byte_count_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      grant_reg       <= 2'b00;
      last_data_reg   <= 1'b1;
      tran_data_reg   <= '0;
      tran_uart_reg   <= 1'b0;
      ack_reg         <= 2'b00;
      byte_count_reg  <= 16'd0;
      timeout_err_reg <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_data_reg   <= last_data_next;
      tran_data_reg   <= tran_data_next;
      tran_uart_reg   <= tran_uart_next;
      ack_reg         <= ack_next;
      byte_count_reg  <= byte_count_next;
      timeout_err_reg <= timeout_err_next;
      wait_cnt_reg    <= wait_cnt_next;
    end
  end

  assign meta_ack    = ack_reg[0];
  assign data_ack    = ack_reg[1];
  assign tran_uart   = tran_uart_reg;
  assign tran_data   = tran_data_reg;
  assign grant       = grant_reg;
  assign byte_count  = byte_count_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration table, directed corner sequences and
// randomized bursts checked against a transaction-level model and a UART stand-in.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        meta_req = 1'b0, meta_valid = 1'b0;
  logic [7:0]  meta_byte = 8'h00;
  logic        data_req = 1'b0, data_valid = 1'b0;
  logic [7:0]  data_byte = 8'h00;
  logic        meta_ack, data_ack, tran_uart, timeout_err, tx_busy;
  logic [7:0]  tran_data;
  logic [1:0]  grant;
  logic [15:0] byte_count;

  // UART stand-in: after a strobe, waits uart_delay cycles, then stays busy uart_len cycles.
  logic uart_busy;
  logic force_busy = 1'b0;
  bit   uart_dead = 1'b0;
  int   uart_len = 10, uart_delay = 0;
  int   delay_cnt, busy_cnt;
  bit   armed;
  assign tx_busy = uart_busy | force_busy;

  int total = 0, bad = 0;
  int strobes = 0, macks = 0, dacks = 0;
  bit outstanding = 1'b0;

  typedef struct {
    bit         m;
    bit         d;
    logic [1:0] g;
  } arb_vec_t;
  arb_vec_t arb_tab [9];

  uart_tx_arbiter #(.BYTE_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .meta_req(meta_req), .meta_valid(meta_valid), .meta_byte(meta_byte), .meta_ack(meta_ack),
    .data_req(data_req), .data_valid(data_valid), .data_byte(data_byte), .data_ack(data_ack),
    .tran_uart(tran_uart), .tran_data(tran_data), .tx_busy(tx_busy),
    .grant(grant), .byte_count(byte_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset_n) begin
      uart_busy <= 1'b0; armed <= 1'b0; delay_cnt <= 0; busy_cnt <= 0;
    end else if (tran_uart && !uart_dead) begin
      armed <= 1'b1; delay_cnt <= uart_delay; busy_cnt <= uart_len;
    end else if (armed) begin
      if (delay_cnt > 0) delay_cnt <= delay_cnt - 1;
      else begin uart_busy <= 1'b1; armed <= 1'b0; end
    end else if (uart_busy) begin
      if (busy_cnt <= 1) uart_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One clock; samples outputs 1 time unit after the edge and checks pulse invariants.
  task automatic tick();
    @(posedge clock); #1;
    if (tran_uart) begin
      strobes++;
      check("one_strobe_per_ack", 32'(outstanding), 0);
      check("strobe_has_owner", 32'(grant != 2'b00), 1);
      outstanding = 1'b1;
    end
    if (meta_ack || data_ack) begin
      check("ack_exclusive", 32'(meta_ack & data_ack), 0);
      check("ack_to_owner", 32'({data_ack, meta_ack}), 32'(grant));
      outstanding = 1'b0;
    end
    if (meta_ack) macks++;
    if (data_ack) dacks++;
  endtask

  task automatic set_req(input bit m, input bit d);
    meta_req = m;
    data_req = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_tran_uart"}, 32'(tran_uart), 0);
    check({tag, "_tran_data"}, 32'(tran_data), 0);
    check({tag, "_meta_ack"}, 32'(meta_ack), 0);
    check({tag, "_data_ack"}, 32'(data_ack), 0);
    check({tag, "_byte_count"}, 32'(byte_count), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  // Present one byte on the owner side; returns cycles until the strobe is seen.
  task automatic send_byte(input bit owner, input logic [7:0] b, output int lat);
    if (owner) begin data_valid = 1'b1; data_byte = b; end
    else begin meta_valid = 1'b1; meta_byte = b; end
    lat = 0;
    do begin tick(); lat++; end while (!tran_uart && lat < 60);
    check("strobe_seen", 32'(tran_uart), 1);
    check("tran_data", 32'(tran_data), 32'(b));
    if (owner) begin data_valid = 1'b0; data_byte = 8'($urandom); end
    else begin meta_valid = 1'b0; meta_byte = 8'($urandom); end
  endtask

  task automatic wait_ack(input bit owner, input logic [7:0] b, output int n);
    n = 0;
    do begin tick(); n++; end while (!(owner ? data_ack : meta_ack) && n < 60);
    check("ack_seen", 32'(owner ? data_ack : meta_ack), 1);
    check("tran_data_hold", 32'(tran_data), 32'(b));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!tx_busy && n < 20) begin tick(); n++; end
    check("busy_seen", 32'(tx_busy), 1);
  endtask

  int  lat, n, s0, m0, d0, sel, nbytes, gap;
  bit  m, d, exp_owner, model_last;
  logic [7:0] b;

  initial begin
    arb_tab[0] = '{1'b1, 1'b1, 2'b01};
    arb_tab[1] = '{1'b1, 1'b1, 2'b10};
    arb_tab[2] = '{1'b1, 1'b0, 2'b01};
    arb_tab[3] = '{1'b1, 1'b0, 2'b01};
    arb_tab[4] = '{1'b1, 1'b1, 2'b10};
    arb_tab[5] = '{1'b0, 1'b1, 2'b10};
    arb_tab[6] = '{1'b1, 1'b1, 2'b01};
    arb_tab[7] = '{1'b0, 1'b1, 2'b10};
    arb_tab[8] = '{1'b1, 1'b1, 2'b01};

    reset_n = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    check("idle_no_req", 32'(grant), 0);

    for (int i = 0; i < 9; i++) begin
      set_req(arb_tab[i].m, arb_tab[i].d);
      tick();
      check($sformatf("arb_grant_%0d", i), 32'(grant), 32'(arb_tab[i].g));
      check($sformatf("arb_count_clear_%0d", i), 32'(byte_count), 0);
      set_req(1'b0, 1'b0);
      tick();
      check($sformatf("arb_release_%0d", i), 32'(grant), 0);
    end

    // Meta burst of two bytes through a 10-cycle-busy UART.
    uart_len = 10; uart_delay = 0;
    set_req(1'b1, 1'b0);
    tick();
    check("burst_grant", 32'(grant), 32'(2'b01));
    s0 = strobes; m0 = macks; d0 = dacks;
    send_byte(1'b0, 8'h3A, lat);
    check("burst_latency1", lat, 1);
    wait_ack(1'b0, 8'h3A, n);
    check("burst_ack_delay", n, 13);
    send_byte(1'b0, 8'hC5, lat);
    check("burst_latency2", lat, 1);
    wait_ack(1'b0, 8'hC5, n);
    check("burst_strobes", strobes - s0, 2);
    check("burst_meta_acks", macks - m0, 2);
    check("burst_data_acks", dacks - d0, 0);
    check("burst_count", 32'(byte_count), 2);
    set_req(1'b0, 1'b0);
    tick(); tick(); tick();
    check("release_grant", 32'(grant), 0);
    check("count_held", 32'(byte_count), 2);
    check("data_held", 32'(tran_data), 32'(8'hC5));

    // UART already busy while granted: no strobe until it goes idle.
    set_req(1'b1, 1'b0);
    tick();
    check("busy_grant", 32'(grant), 32'(2'b01));
    force_busy = 1'b1; meta_valid = 1'b1; meta_byte = 8'h55;
    s0 = strobes;
    repeat (5) tick();
    check("busy_blocks_strobe", strobes - s0, 0);
    force_busy = 1'b0;
    send_byte(1'b0, 8'h55, lat);
    check("busy_release_latency", lat, 1);
    wait_ack(1'b0, 8'h55, n);
    set_req(1'b0, 1'b0);
    tick();

    // Data burst; meta requests mid-burst and must wait for data to release.
    set_req(1'b0, 1'b1);
    tick();
    check("data_grant", 32'(grant), 32'(2'b10));
    m0 = macks;
    send_byte(1'b1, 8'h11, lat);
    wait_ack(1'b1, 8'h11, n);
    meta_req = 1'b1; meta_valid = 1'b1; meta_byte = 8'hEE;
    send_byte(1'b1, 8'h22, lat);
    wait_ack(1'b1, 8'h22, n);
    check("no_preempt_grant", 32'(grant), 32'(2'b10));
    check("no_preempt_meta_ack", macks - m0, 0);
    check("no_preempt_count", 32'(byte_count), 2);
    data_req = 1'b0;
    tick();
    check("handover_gap", 32'(grant), 0);
    tick();
    check("handover_meta", 32'(grant), 32'(2'b01));
    send_byte(1'b0, 8'hEE, lat);
    check("handover_latency", lat, 1);
    wait_ack(1'b0, 8'hEE, n);
    set_req(1'b0, 1'b0);
    tick();

    // Owner drops req while the UART is busy: the byte still completes.
    uart_len = 6;
    set_req(1'b1, 1'b0);
    tick();
    s0 = strobes;
    send_byte(1'b0, 8'h77, lat);
    wait_busy();
    meta_req = 1'b0;
    wait_ack(1'b0, 8'h77, n);
    check("drop_count", 32'(byte_count), 1);
    check("drop_strobes", strobes - s0, 1);
    tick();
    check("drop_release", 32'(grant), 0);
    uart_len = 10;

    // UART never goes busy: timeout after 16 cycles of waiting.
    set_req(1'b1, 1'b0);
    tick();
    uart_dead = 1'b1;
    send_byte(1'b0, 8'hA5, lat);
    check("timeout_not_yet", 32'(timeout_err), 0);
    wait_ack(1'b0, 8'hA5, n);
    check("timeout_ack_delay", n, 17);
    check("timeout_err_set", 32'(timeout_err), 1);
    check("timeout_count", 32'(byte_count), 0);
    uart_dead = 1'b0;
    send_byte(1'b0, 8'h5A, lat);
    check("timeout_back_granted", lat, 1);
    wait_ack(1'b0, 8'h5A, n);
    check("timeout_then_count", 32'(byte_count), 1);
    check("timeout_sticky", 32'(timeout_err), 1);
    set_req(1'b0, 1'b0);
    tick();

    // Reset while the UART is busy on a data byte.
    set_req(1'b0, 1'b1);
    tick();
    send_byte(1'b1, 8'h3C, lat);
    wait_busy();
    tick();
    m0 = macks; d0 = dacks;
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    outstanding = 1'b0;
    reset_n = 1'b1;
    set_req(1'b0, 1'b0);
    repeat (15) tick();
    check("midreset_no_ack", (macks - m0) + (dacks - d0), 0);

    // Randomized bursts against the round-robin / byte-order model.
    model_last = 1'b1;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(1, 3);
      m = sel[0]; d = sel[1];
      exp_owner = (m && d) ? !model_last : d;
      uart_len = $urandom_range(1, 8);
      uart_delay = $urandom_range(0, 4);
      if (exp_owner) begin meta_valid = 1'($urandom); meta_byte = 8'($urandom); end
      else begin data_valid = 1'($urandom); data_byte = 8'($urandom); end
      set_req(m, d);
      tick();
      check($sformatf("rand_grant_%0d", it), 32'(grant), exp_owner ? 32'(2'b10) : 32'(2'b01));
      nbytes = $urandom_range(1, 3);
      for (int k = 0; k < nbytes; k++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        b = 8'($urandom);
        send_byte(exp_owner, b, lat);
        check("rand_latency", lat, 1);
        wait_ack(exp_owner, b, n);
        check("rand_ack_delay", n, uart_delay + uart_len + 3);
        check("rand_count", 32'(byte_count), k + 1);
      end
      set_req(1'b0, 1'b0);
      meta_valid = 1'b0; data_valid = 1'b0;
      tick();
      check("rand_release", 32'(grant), 0);
      model_last = exp_owner;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
